imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH_WORDS, default 1024, meaning the number of 32-bit instruction words (power of two, at least 2).
REQ-002 The block SHALL have parameter MEM_INIT_FILE, default "program.hex", meaning the $readmemh image (one 32-bit hex word per line) loaded at time 0.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0 (4-byte aligned).
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, meaning extra read cycles per fetch (0..15).
REQ-005 The block SHALL use one clock and a synchronous, active-low reset, with ports as follows.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 req_valid  in  1  fetch request present.
REQ-009 req_ready  out  1  block can accept a request this cycle.
REQ-010 req_addr  in  32  byte address (PC) of the fetch.
REQ-011 flush  in  1  drop the in-flight fetch (branch redirect).
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  consumer accepts the response.
REQ-014 rsp_instr  out  32  fetched instruction word.
REQ-015 rsp_pc  out  32  req_addr of the request this response answers.
REQ-016 rsp_fault  out  1  fetch fault (see Configuration).

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-018 A request SHALL be accepted when req_valid && req_ready at a rising edge; req_addr SHALL be captured at that edge.
REQ-019 req_ready SHALL equal !flush && rst_n && (state==IDLE || (state==RESP && rsp_ready)), giving back-to-back fetches with no bubble.
REQ-020 On acceptance, the state SHALL go to WAIT with the counter loaded to WAIT_STATES-1 if WAIT_STATES>0, else to RESP.
REQ-021 In WAIT, the counter SHALL decrement each cycle; the state SHALL go to RESP when the counter is 0.
REQ-022 rsp_valid SHALL rise exactly WAIT_STATES+1 cycles after the acceptance edge; rsp_valid SHALL be high if and only if state==RESP.
REQ-023 In RESP with rsp_ready=0, rsp_valid, rsp_instr, rsp_pc and rsp_fault SHALL remain stable.
REQ-024 In RESP with rsp_ready=1 and no new acceptance, the state SHALL go to IDLE.
REQ-025 The memory index SHALL be bits [log2(MEM_DEPTH_WORDS)+1:2] of (req_addr - BASE_ADDR); the array SHALL be read-only.
REQ-026 Memory SHALL be read using the captured address, so a change on req_addr after acceptance has no effect.
REQ-027 flush=1 SHALL force the state to IDLE at the next edge from any state, discard the pending response, and accept no request that cycle.
REQ-028 If flush and rsp_valid&&rsp_ready coincide, that response SHALL count as consumed and the state SHALL go to IDLE.
REQ-029 With req_valid=0, the block SHALL never leave IDLE.

Reset
REQ-030 When rst_n=0 at an edge, the state SHALL go to IDLE and the counter to 0.
REQ-031 When rst_n=0 at an edge, the outputs SHALL reset to rsp_valid=0, rsp_instr=32'h0000_0013, rsp_pc=0, rsp_fault=0; req_ready SHALL be 0 while rst_n=0.
REQ-032 Reset during WAIT or RESP SHALL abort the fetch, and no response SHALL be produced for it afterwards.
REQ-033 Memory contents SHALL be unaffected by reset.

Configuration
REQ-034 The block SHALL have one macro, IMEM_FETCH_FAULT_EN.
REQ-035 With IMEM_FETCH_FAULT_EN defined, the response SHALL have rsp_fault=1 and rsp_instr=32'h0000_0013 when req_addr[1:0]!=0, req_addr<BASE_ADDR, or req_addr-BASE_ADDR>=4*MEM_DEPTH_WORDS; timing SHALL be identical to a normal fetch.
REQ-036 Without IMEM_FETCH_FAULT_EN, rsp_fault SHALL be tied to 0, addr[1:0] SHALL be ignored, and out-of-range addresses SHALL wrap modulo MEM_DEPTH_WORDS.

Verification
REQ-037 WAIT_STATES=0, mem[0..2]=A,B,C, req 0x0,0x4,0x8 back-to-back with rsp_ready=1: responses A,B,C on consecutive cycles, each 1 cycle after acceptance, rsp_pc matching.
REQ-038 WAIT_STATES=3, req 0x10: rsp_valid rises exactly 4 cycles after acceptance with mem[4]; req_ready=0 during WAIT.
REQ-039 rsp_ready held 0 for 5 cycles in RESP while req_addr toggles: outputs stable, req_ready=0; then rsp_ready=1 releases to IDLE.
REQ-040 flush asserted in WAIT (WAIT_STATES=2) and in RESP: no rsp_valid for the dropped fetch; the next request is accepted one cycle later with correct data.
REQ-041 With IMEM_FETCH_FAULT_EN, req 0x2 and 0x1000 (depth 1024): rsp_fault=1 and rsp_instr=0x00000013; without the macro, 0x1000 returns mem[0] with fault 0.
REQ-042 rst_n=0 asserted mid-WAIT: the next cycle shows rsp_valid=0, rsp_instr=0x00000013, rsp_pc=0, and no late response.

Source files
------------

// File: rtl/imem_fetch.sv
// imem_fetch: single-outstanding instruction fetch unit in front of a
// read-only instruction memory.
//
// Ports
//   clk        in   1   clock, all state changes on the rising edge
//   rst_n      in   1   synchronous active-low reset
//   req_valid  in   1   fetch request present
//   req_ready  out  1   request accepted this cycle when req_valid is high
//   req_addr   in  32   byte address (PC) of the fetch
//   flush      in   1   drop the in-flight fetch (branch redirect)
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   consumer accepts the response
//   rsp_instr  out 32   fetched instruction word
//   rsp_pc     out 32   req_addr of the answered request
//   rsp_fault  out  1   fetch fault
//
// Build option
//   IMEM_FETCH_FAULT_EN  when defined, misaligned or out-of-range fetches
//                        answer with rsp_fault=1 and a NOP; otherwise the
//                        low address bits are ignored and the index wraps.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no fetch outstanding, ready for a request
// WAIT  | fetch accepted, burning wait states (cnt_q counts down to 0)
// RESP  | response presented, held until rsp_ready or flush

module imem_fetch #(
   parameter int unsigned MEM_DEPTH_WORDS = 1024,
   parameter string       MEM_INIT_FILE   = "program.hex",
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned WAIT_STATES     = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic [31:0] rsp_pc,
   output logic        rsp_fault
);

   localparam int unsigned AW       = $clog2(MEM_DEPTH_WORDS);
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] instr_q, pc_q;
   logic        fault_q;

   logic          accept;
   logic [AW-1:0] rd_idx;
   logic          rd_fault;
   logic [31:0]   rd_instr;

   logic [31:0] mem [MEM_DEPTH_WORDS];

   // Truncating the word offset to AW bits gives the modulo-depth wrap.
   assign rd_idx = AW'((req_addr - BASE_ADDR) >> 2);

`ifdef IMEM_FETCH_FAULT_EN
   logic [31:0] rd_off;
   assign rd_off   = req_addr - BASE_ADDR;
   assign rd_fault = (req_addr[1:0] != 2'b00) ||
                     (req_addr < BASE_ADDR) ||
                     ({1'b0, rd_off} >= 33'(4 * MEM_DEPTH_WORDS));
`else
   assign rd_fault = 1'b0;
`endif

   assign rd_instr = rd_fault ? NOP : mem[rd_idx];

   // Ready in RESP only when the current response leaves this cycle, so
   // consecutive fetches run without a bubble.
   assign req_ready = !flush && rst_n &&
                      ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
      end else if (accept) begin
         if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
         end else begin
            state_d = RESP;
         end
      end else begin
         case (state_q)
            IDLE: ;
            WAIT: begin
               if (cnt_q == 4'd0) state_d = RESP;
               else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
               if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // The word is read at the acceptance edge from the live address, so
   // later changes on req_addr cannot disturb the fetch in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         instr_q <= NOP;
         pc_q    <= 32'h0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            instr_q <= rd_instr;
            pc_q    <= req_addr;
            fault_q <= rd_fault;
         end
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_instr = instr_q;
   assign rsp_pc    = pc_q;
   assign rsp_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: two instances (0 and 3 wait states) share the same
// stimulus. A per-instance transaction model (outstanding flag plus age
// since acceptance) predicts handshakes; expected responses are queued at
// acceptance and compared while the DUT presents them.

module tb_imem_fetch;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          WS0   = 0;
   localparam int          WS1   = 3;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, req_valid, flush, rsp_ready;
   logic [31:0] req_addr;

   logic        req_ready_w [2];
   logic        rsp_valid_w [2];
   logic        rsp_fault_w [2];
   logic [31:0] rsp_instr_w [2];
   logic [31:0] rsp_pc_w    [2];

   logic [31:0] tbmem [DEPTH];
   exp_t        exp_q [2][$];
   bit          pend    [2];
   int          age     [2];
   bit          rstouts [2];
   bit          chk_en = 1'b0;
   int          n_chk  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   imem_fetch #(.MEM_DEPTH_WORDS(DEPTH), .MEM_INIT_FILE(""), .BASE_ADDR(BASE),
                .WAIT_STATES(WS0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w[0]),
      .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid_w[0]),
      .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_w[0]), .rsp_pc(rsp_pc_w[0]),
      .rsp_fault(rsp_fault_w[0]));

   imem_fetch #(.MEM_DEPTH_WORDS(DEPTH), .MEM_INIT_FILE(""), .BASE_ADDR(BASE),
                .WAIT_STATES(WS1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w[1]),
      .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid_w[1]),
      .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_w[1]), .rsp_pc(rsp_pc_w[1]),
      .rsp_fault(rsp_fault_w[1]));

   function automatic exp_t ref_fetch(input logic [31:0] a);
      exp_t   e;
      longint m;
      longint off;
      longint w;
      m   = 4 * DEPTH;
      off = longint'(a) - longint'(BASE);
      w   = (((off % m) + m) % m) / 4;
      e.pc    = a;
      e.fault = 1'b0;
      e.instr = tbmem[int'(w)];
`ifdef IMEM_FETCH_FAULT_EN
      if ((a % 4) != 0 || off < 0 || off >= m) begin
         e.fault = 1'b1;
         e.instr = 32'h0000_0013;
      end
`endif
      return e;
   endfunction

   task automatic check(input string what, input int k, input logic [31:0] act,
                        input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t: got %h expected %h", what, k, $time, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            bit ev;
            bit er;
            int ws;
            ws = (k == 0) ? WS0 : WS1;
            ev = pend[k] && (age[k] >= ws);
            er = rst_n && !flush && (!pend[k] || (ev && rsp_ready));
            check("rsp_valid", k, 32'(rsp_valid_w[k]), 32'(ev));
            check("req_ready", k, 32'(req_ready_w[k]), 32'(er));
            if (ev) begin
               if (exp_q[k].size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL rsp_unexpected dut%0d t=%0t: got response with empty scoreboard, expected none",
                           k, $time);
               end else begin
                  check("rsp_instr", k, rsp_instr_w[k], exp_q[k][0].instr);
                  check("rsp_pc",    k, rsp_pc_w[k],    exp_q[k][0].pc);
                  check("rsp_fault", k, 32'(rsp_fault_w[k]), 32'(exp_q[k][0].fault));
               end
            end
            if (rstouts[k]) begin
               check("reset_instr", k, rsp_instr_w[k], 32'h0000_0013);
               check("reset_pc",    k, rsp_pc_w[k],    32'h0);
               check("reset_fault", k, 32'(rsp_fault_w[k]), 32'h0);
            end
            if (pend[k]) age[k]++;
            if (!rst_n) begin
               exp_q[k].delete();
               pend[k]    = 1'b0;
               rstouts[k] = 1'b1;
            end else begin
               if (ev && rsp_ready) begin
                  void'(exp_q[k].pop_front());
                  pend[k] = 1'b0;
               end
               if (flush) begin
                  exp_q[k].delete();
                  pend[k] = 1'b0;
               end else if (er && req_valid) begin
                  exp_q[k].push_back(ref_fetch(req_addr));
                  pend[k]    = 1'b1;
                  age[k]     = 0;
                  rstouts[k] = 1'b0;
               end
            end
         end
      end
   end

   task automatic drive(input bit rn, input bit rv, input logic [31:0] a,
                        input bit fl, input bit rr);
      rst_n     = rn;
      req_valid = rv;
      req_addr  = a;
      flush     = fl;
      rsp_ready = rr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(7, 0))
         0, 1, 2, 3, 4: a = BASE + {20'h0, 10'($urandom_range(DEPTH - 1, 0)), 2'b00};
         5:             a = BASE + {20'h0, 10'($urandom_range(DEPTH - 1, 0)), 2'($urandom_range(3, 1))};
         6:             a = BASE + 32'(4 * DEPTH) + {20'h0, 10'($urandom), 2'b00};
         default:       a = $urandom;
      endcase
      return a;
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         tbmem[i]        = $urandom;
         u_dut0.mem[i]   = tbmem[i];
         u_dut1.mem[i]   = tbmem[i];
      end
      for (int k = 0; k < 2; k++) begin
         pend[k]    = 1'b0;
         age[k]     = 0;
         rstouts[k] = 1'b1;
      end
      rst_n     = 1'b0;
      req_valid = 1'b0;
      flush     = 1'b0;
      rsp_ready = 1'b1;
      req_addr  = 32'h0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

      // back-to-back fetches of words 0..2
      drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 32'h4, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 32'h8, 1'b0, 1'b1);
      idle(6);

      // stalled response while req_addr toggles
      drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
      idle(3);

      // flush one cycle after acceptance, then a fresh request
      drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 32'h24, 1'b0, 1'b1);
      idle(5);

      // flush while the response is stalled
      drive(1'b1, 1'b1, 32'h30, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 32'h38, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 32'h34, 1'b0, 1'b1);
      idle(5);

      // flush coinciding with the response handshake
      drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      idle(3);

      // misaligned and past-the-end addresses
      drive(1'b1, 1'b1, 32'h2, 1'b0, 1'b1);
      idle(4);
      drive(1'b1, 1'b1, 32'h1000, 1'b0, 1'b1);
      idle(4);

      // reset in the middle of a wait-state fetch
      drive(1'b1, 1'b1, 32'h50, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      idle(6);

      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(59, 0) != 0),
               ($urandom_range(2, 0) != 0),
               rand_addr(),
               ($urandom_range(9, 0) == 0),
               ($urandom_range(3, 0) != 0));
      end
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
